// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state encoding and default parameters for the CDC multi-cycle-path sender.
package cdc_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK} sender_state_t;
    localparam int DEF_WIDTH          = 5;
    localparam int DEF_DEPTH          = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop synchronizer for one asynchronous level; only the last stage is used.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end
    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/cdc_mcp_sender.sv
// cdc_mcp_sender: FIFO-buffered words are launched with a request toggle and held on DATA_O
// until the synchronized acknowledge toggle matches, with a sticky acknowledge timeout.
module cdc_mcp_sender
    import cdc_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [WIDTH-1:0] DATA_I,
    input  logic             VALID_I,
    output logic             READY_O,
    output logic [WIDTH-1:0] DATA_O,
    output logic             REQ_O,
    input  logic             ACK_I,
    input  logic             CLR_I,
    output logic             BUSY_O,
    output logic             TIMEOUT_O
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    sender_state_t    state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_q;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q;
    logic             req_q, timeout_q, ack_s, empty, full, push, pop, acked, hit;

    sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i(CLK_I),
        .rst_i(RST_I),
        .d_i  (ACK_I),
        .q_o  (ack_s)
    );

    always_comb begin
        empty     = wr_q == rd_q;
        full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        acked     = ack_s == req_q;
        push      = VALID_I && !full;
        pop       = !empty && (state_q == IDLE || (state_q == WAIT_ACK && acked));
        hit       = TIMEOUT_CYCLES != 0 && state_q == WAIT_ACK && !acked && cnt_q == CNT_MAX - CW'(1);
        wr_d      = wr_q + PW'(push);
        rd_d      = rd_q + PW'(pop);
        READY_O   = !full && !RST_I;
        BUSY_O    = state_q != IDLE || !empty;
        DATA_O    = data_q;
        REQ_O     = req_q;
        TIMEOUT_O = timeout_q;
    end

    always_ff @(posedge CLK_I) begin
        if (push) mem_q[wr_q[AW-1:0]] <= DATA_I;
    end

    // The counter saturates so a cleared timeout is not re-raised by the same stuck transfer.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            req_q     <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            timeout_q <= hit ? 1'b1 : CLR_I ? 1'b0 : timeout_q;
            if (pop) data_q <= mem_q[rd_q[AW-1:0]];
            case (state_q)
                IDLE:     state_q <= pop ? LAUNCH : IDLE;
                LAUNCH: begin
                    req_q   <= !req_q;
                    cnt_q   <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    state_q <= !acked ? WAIT_ACK : pop ? LAUNCH : IDLE;
                    if (!acked && cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
                end
                default:  state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_mcp_sender.sv
// tb_cdc_mcp_sender: randomized scoreboard bench with a looped-back destination model.
module tb_cdc_mcp_sender;
    localparam int W  = 5;
    localparam int D  = 4;
    localparam int SS = 2;
    localparam int TO = 16;

    logic         clk = 0, rst = 1, valid = 0, clr = 0, ack_en = 1;
    logic [W-1:0] din = '0;
    logic         ready, req, ack, busy, tmo, acc;
    logic [W-1:0] dout;
    int           checks = 0, failures = 0, toggles = 0, delivered = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    cdc_mcp_sender #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .DATA_I   (din),
        .VALID_I  (valid),
        .READY_O  (ready),
        .DATA_O   (dout),
        .REQ_O    (req),
        .ACK_I    (ack),
        .CLR_I    (clr),
        .BUSY_O   (busy),
        .TIMEOUT_O(tmo)
    );

    // Destination: req crosses two flops, a third flop returns the ack toggle and captures the word.
    logic         r1, r2, ack_q, got_v;
    logic [W-1:0] got_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r1 <= 0; r2 <= 0; ack_q <= 0; got_v <= 0; got_d <= '0;
        end else begin
            r1 <= req; r2 <= r1; got_v <= 0;
            if (ack_en && r2 != ack_q) begin
                ack_q <= r2; got_v <= 1; got_d <= dout;
            end
        end
    end
    assign ack = ack_q;

    logic [SS-1:0] as_q;
    always @(posedge clk or posedge rst) as_q <= rst ? '0 : {as_q[SS-2:0], ack};

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    logic         p_req = 0, p_acks = 0, p_rst = 1;
    logic [W-1:0] p_data = '0;
    always @(negedge clk) begin
        if (got_v) begin
            delivered++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_word actual=%0h required=none", got_d);
            end else chk("delivered_word", 32'(got_d), 32'(exp_q.pop_front()));
        end
        if (!rst && !p_rst && dout != p_data) chk("data_change_while_pending", 32'(p_req == p_acks), 1);
        if (!rst && req != p_req) toggles++;
        p_req = req; p_acks = as_q[SS-1]; p_rst = rst; p_data = dout;
    end

    task automatic send(input logic [W-1:0] w, output logic a);
        @(negedge clk); valid = 1; din = w; a = ready;
        @(posedge clk);
        if (a) exp_q.push_back(w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); valid = 0; end
    endtask

    task automatic drain(input string n);
        int k = 0;
        @(negedge clk); valid = 0;
        while ((busy || exp_q.size() != 0) && k < 500) begin @(negedge clk); k++; end
        chk(n, 32'(k < 500), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, t0, tries;
        logic r0;
        logic [W-1:0] w;
        repeat (3) @(negedge clk);
        chk("rst_req", req, 0); chk("rst_data", 32'(dout), 0); chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0); chk("rst_timeout", tmo, 0);
        rst = 0;
        @(negedge clk); chk("ready_after_rst", ready, 1);

        send(5'h15, acc); chk("single_accept", acc, 1);
        @(negedge clk); valid = 0; chk("lat_data_t0", 32'(dout), 0); chk("lat_req_t0", req, 0);
        @(negedge clk); chk("lat_data_t1", 32'(dout), 32'h15); chk("lat_req_t1", req, 0);
        @(negedge clk); chk("lat_req_t2", req, 1);
        drain("single_drain"); chk("single_busy", busy, 0);

        ack_en = 0; d0 = delivered;
        send(5'h0A, acc); idle(4);
        for (int i = 0; i < 6; i++) begin
            send(5'($urandom_range(0, 31)), acc);
            chk($sformatf("bp_accept%0d", i), acc, 32'(i < D));
        end
        idle(1); chk("bp_ready_full", ready, 0);
        ack_en = 1; drain("bp_drain"); chk("bp_delivered", delivered - d0, D + 1);
        @(negedge clk); clr = 1; @(negedge clk); clr = 0;

        ack_en = 0; r0 = req; clr = 1; t0 = toggles;
        send(5'h0C, acc);
        @(negedge clk); valid = 0;
        @(negedge clk);
        @(negedge clk); chk("to_req_toggle", req, !r0);
        repeat (TO - 1) @(negedge clk);
        chk("to_not_yet", tmo, 0);
        @(negedge clk); chk("to_set_wins_clr", tmo, 1); clr = 0;
        @(negedge clk); chk("to_sticky", tmo, 1); clr = 1;
        @(negedge clk); clr = 0; chk("to_cleared", tmo, 0);
        repeat (5) @(negedge clk);
        chk("to_stays_clear", tmo, 0); chk("to_no_resend", toggles - t0, 1);
        ack_en = 1; drain("to_drain"); chk("to_busy", busy, 0);

        if (req == 1'b1) begin send(5'h03, acc); drain("rst_prep_drain"); end
        ack_en = 0;
        send(5'h1F, acc); send(5'h11, acc); send(5'h12, acc); idle(3);
        chk("pre_rst_req", req, 1); chk("pre_rst_data", 32'(dout), 32'h1F);
        @(negedge clk); #2 rst = 1; #1;
        chk("mid_rst_req", req, 0); chk("mid_rst_data", 32'(dout), 0);
        chk("mid_rst_ready", ready, 0); chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        t0 = toggles;
        repeat (3) @(negedge clk);
        rst = 0; ack_en = 1;
        repeat (20) @(negedge clk);
        chk("post_rst_toggles", toggles - t0, 0); chk("post_rst_busy", busy, 0);

        d0 = delivered;
        for (int i = 0; i < 32; i++) begin
            w = 5'($urandom_range(0, 31)); tries = 0; acc = 0;
            while (!acc && tries < 50) begin send(w, acc); tries++; end
            if (!acc) chk("stream_accept", acc, 1);
            idle($urandom_range(1, 3));
        end
        drain("stream_drain");
        chk("stream_delivered", delivered - d0, 32); chk("stream_timeout", tmo, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdc_mcp_sender.md
CDC_MCP_SENDER -- requirements
Module: cdc_mcp_sender

Interface
REQ-001 The module SHALL have parameter WIDTH, default 5: data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4: input FIFO entries, a power of two, minimum 2.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2: ACK_I synchronizer depth, minimum 2.
REQ-004 The module SHALL have parameter TIMEOUT_CYCLES, default 1024: acknowledge timeout in cycles; 0 disables the timeout.
REQ-005 The module SHALL have port CLK_I, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The module SHALL have port RST_I, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The module SHALL have port DATA_I, input, WIDTH bits: word offered for transfer.
REQ-008 The module SHALL have port VALID_I, input, 1 bit: DATA_I is valid.
REQ-009 The module SHALL have port READY_O, output, 1 bit: the FIFO can accept a word.
REQ-010 The module SHALL have port DATA_O, output, WIDTH bits: registered word in flight to the destination domain.
REQ-011 The module SHALL have port REQ_O, output, 1 bit: registered request toggle; each transition announces a new DATA_O.
REQ-012 The module SHALL have port ACK_I, input, 1 bit: acknowledge toggle from the destination domain, asynchronous to CLK_I.
REQ-013 The module SHALL have port CLR_I, input, 1 bit: synchronous clear of TIMEOUT_O.
REQ-014 The module SHALL have port BUSY_O, output, 1 bit: a transfer is in flight or the FIFO is non-empty.
REQ-015 The module SHALL have port TIMEOUT_O, output, 1 bit: sticky acknowledge-timeout flag.

Function
REQ-016 The module SHALL accept a word on every edge where VALID_I and READY_O are both 1; READY_O SHALL equal not-full, and a push while full SHALL be ignored (no same-cycle pop bypass).
REQ-017 The module SHALL pass ACK_I through SYNC_STAGES flops before use; only the last stage (ack_s) SHALL be observed.
REQ-018 The module SHALL implement states IDLE, LAUNCH and WAIT_ACK.
REQ-019 In IDLE with FIFO non-empty, the module SHALL load DATA_O from the FIFO head, pop it, and enter LAUNCH.
REQ-020 In LAUNCH, the module SHALL invert REQ_O and enter WAIT_ACK, so DATA_O is stable at least one cycle before REQ_O toggles.
REQ-021 In WAIT_ACK, when ack_s equals REQ_O, the module SHALL reload DATA_O and enter LAUNCH if the FIFO is non-empty, otherwise enter IDLE.
REQ-022 DATA_O SHALL change only in IDLE or on leaving WAIT_ACK, never while ack_s differs from REQ_O.
REQ-023 Latency SHALL be: push accepted at edge t into an empty FIFO in IDLE, DATA_O updated at t+1, REQ_O toggled at t+2.
REQ-024 A timeout counter SHALL count cycles in WAIT_ACK, clearing on entry; on reaching TIMEOUT_CYCLES it SHALL set TIMEOUT_O, and the FSM SHALL keep waiting without resending.
REQ-025 CLR_I SHALL clear TIMEOUT_O on the next edge; if CLR_I and a new timeout occur on the same edge, the set SHALL win.
REQ-026 BUSY_O SHALL be 1 when the state is not IDLE or the FIFO is non-empty.
REQ-027 FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full and empty SHALL be decoded from the MSB and the remaining pointer bits.

Reset
REQ-028 While RST_I is 1, the module SHALL hold: state IDLE; FIFO empty; DATA_O 0; REQ_O 0; ack synchronizer 0; counter 0; TIMEOUT_O 0; BUSY_O 0; READY_O 0.
REQ-029 Reset mid-transfer SHALL abandon the in-flight word and all FIFO contents; the destination SHALL be reset in the same interval so its ack toggle returns to 0.

Structure
REQ-030 The package cdc_pkg SHALL hold the state enum typedef sender_state_t (IDLE, LAUNCH, WAIT_ACK) and the default parameter constants.
REQ-031 The ACK_I synchronizer SHALL be a separate sub-module, sync_bit, parameterized by SYNC_STAGES.

Verification
REQ-032 The bench SHALL cover single word: push 5'h15 after reset with ACK_I looped back through 3 flops -> DATA_O=5'h15 at t+1, REQ_O 0->1 at t+2, BUSY_O=0 after the ack.
REQ-033 The bench SHALL cover back-pressure: push 6 words with ACK_I held 0 -> 4 accepted, READY_O=0 after the 4th push; release the ack -> words delivered in order, one per toggle.
REQ-034 The bench SHALL cover timeout: TIMEOUT_CYCLES=16 with ACK_I stuck -> TIMEOUT_O=1 after 16 WAIT_ACK cycles; CLR_I pulse -> 0; a later ack completes the transfer.
REQ-035 The bench SHALL cover mid-transfer reset: assert RST_I in WAIT_ACK -> REQ_O=0, DATA_O=0 and READY_O=0 immediately, with no further toggles.
REQ-036 The bench SHALL cover streaming: 32 words with a looped-back ack -> DATA_O never changes while ack_s differs from REQ_O; an end-to-end destination scoreboard matches.
